// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM receive demultiplexer.
package tdm_demux_pkg;

    localparam int unsigned CH_NUM_DEF = 4;
    localparam int unsigned W_DEF      = 8;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot index register for the TDM demux: increment with wrap, load-to-1,
// clear, and a flag marking the last slot of a frame.
module tdm_slot_cnt
    import tdm_demux_pkg::*;
#(
    parameter int unsigned CH_NUM = CH_NUM_DEF
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      i_inc,
    input  logic                      i_load1,
    input  logic                      i_clr,
    output logic [$clog2(CH_NUM)-1:0] o_slot,
    output logic                      o_last
);

    localparam int unsigned SW = $clog2(CH_NUM);
    localparam logic [SW-1:0] LAST = SW'(CH_NUM - 1);

    logic [SW-1:0] r_slot;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_slot <= '0;
        end else if (i_clr) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= SW'(1);
        end else if (i_inc) begin
            r_slot <= (r_slot == LAST) ? '0 : r_slot + SW'(1);
        end
    end

    assign o_slot = r_slot;
    assign o_last = (r_slot == LAST);

endmodule

// File: rtl/tdm_demux.sv
// TDM slot-stream demultiplexer: gathers CH_NUM slots per frame and presents
// them together on Y. Optional frame/error counters under TDM_DEMUX_CNT_EN.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned CH_NUM = CH_NUM_DEF,
    parameter int unsigned W      = W_DEF
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      E,
    input  logic [W-1:0]              I,
    input  logic                      I_VLD,
    input  logic                      FS,
    output logic [CH_NUM*W-1:0]       Y,
    output logic                      Y_VLD,
    output logic [$clog2(CH_NUM)-1:0] SLOT,
    output logic                      ERR
`ifdef TDM_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]          FRM_CNT,
    output logic [CNT_W-1:0]          ERR_CNT
`endif
);

    localparam int unsigned SW = $clog2(CH_NUM);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W-1:0]        r_shadow [CH_NUM-1];
    logic [CH_NUM*W-1:0] r_y;
    logic                r_y_vld;
    logic                r_err;

    logic          w_beat;
    logic [SW-1:0] w_slot;
    logic          w_last;
    logic          w_take0;
    logic          w_wr_slot;
    logic          w_inc;
    logic          w_clr;
    logic          w_complete;
    logic          w_err;

    assign w_beat = E & I_VLD;

    tdm_slot_cnt #(
        .CH_NUM (CH_NUM)
    ) u_slot (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_inc   (w_inc),
        .i_load1 (w_take0),
        .i_clr   (w_clr),
        .o_slot  (w_slot),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_take0     = 1'b0;
        w_wr_slot   = 1'b0;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        w_complete  = 1'b0;
        w_err       = 1'b0;
        if (w_beat) begin
            case (r_state)
                HUNT: begin
                    if (FS) begin
                        w_take0     = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    // A sync beat always restarts the frame; early if mid-frame.
                    if (FS) begin
                        w_take0 = 1'b1;
                        w_err   = (w_slot != '0);
                    end else if (w_slot == '0) begin
                        w_err       = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_inc      = 1'b1;
                        w_complete = w_last;
                        w_wr_slot  = ~w_last;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= HUNT;
            r_y     <= '0;
            r_y_vld <= 1'b0;
            r_err   <= 1'b0;
            for (int unsigned k = 0; k < CH_NUM - 1; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_y_vld <= w_complete;
            r_err   <= w_err;
            for (int unsigned k = 0; k < CH_NUM - 1; k++) begin
                if ((w_take0 && k == 0) || (w_wr_slot && w_slot == SW'(k))) begin
                    r_shadow[k] <= I;
                end
            end
            // The last slot bypasses the shadow and lands directly in Y.
            if (w_complete) begin
                for (int unsigned k = 0; k < CH_NUM - 1; k++) begin
                    r_y[k*W +: W] <= r_shadow[k];
                end
                r_y[(CH_NUM-1)*W +: W] <= I;
            end
        end
    end

    assign Y     = r_y;
    assign Y_VLD = r_y_vld;
    assign ERR   = r_err;
    assign SLOT  = w_slot;

`ifdef TDM_DEMUX_CNT_EN
    logic [CNT_W-1:0] r_frm_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_frm_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_complete && r_frm_cnt != '1) begin
                r_frm_cnt <= r_frm_cnt + CNT_W'(1);
            end
            if (w_err && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign FRM_CNT = r_frm_cnt;
    assign ERR_CNT = r_err_cnt;
`endif

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
Receive end of the team's time-division multiplexed link. It is the demultiplexer counterpart of the enabled mux family.
- Accepts a single W-bit slot stream with a frame-sync marker.
- Collects CH_NUM consecutive slots into shadow registers.
- Presents all channels simultaneously on Y as one frame with a one-cycle valid pulse.
- Sits between the link receiver and the per-channel consumers.

Parameters:
CH_NUM, 4, number of channels (slots per frame), >= 2
W, 8, bits per slot / per channel
SW, $clog2(CH_NUM), slot index width (derived, not overridable)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
E  input  1  block enable; low freezes all state
I  input  W  slot data
I_VLD  input  1  I carries a valid slot this cycle
FS  input  1  frame sync; qualified by I_VLD, marks slot 0
Y  output  CH_NUM*W  frame output; channel k at bits [k*W +: W]
Y_VLD  output  1  one-cycle pulse: new frame on Y
SLOT  output  SW  index the next accepted beat will occupy
ERR  output  1  one-cycle pulse: framing error detected

Behaviour:
- Clocking and reset:
  - One clock domain, CLK.
  - RST_N is asynchronous, active-low.
  - Reset values: Y=0, Y_VLD=0, ERR=0, SLOT=0, state=HUNT, shadow registers=0.
- A beat is a cycle with E=1 and I_VLD=1. Nothing advances without a beat, except that Y_VLD and ERR self-clear.
- E=0:
  - Beats are ignored.
  - SLOT, state, shadow and Y all hold.
  - Y_VLD and ERR are driven 0.
- State HUNT:
  - Beat with FS=0 is discarded.
  - Beat with FS=1 writes shadow[0], sets SLOT=1, moves to RUN.
- State RUN, beat with FS=0 and SLOT!=0:
  - Writes shadow[SLOT].
  - SLOT increments.
- Frame completion: on a RUN beat with SLOT==CH_NUM-1:
  - The beat is written to Y[CH_NUM-1] directly.
  - Y[0..CH_NUM-2] is loaded from shadow in the same edge.
  - Y_VLD=1 the following cycle.
  - SLOT wraps to 0.
  - Latency: last slot beat to Y/Y_VLD is 1 cycle.
- Start of the next frame (RUN, SLOT==0):
  - Beat with FS=1 writes shadow[0] and sets SLOT=1.
  - Beat with FS=0 (missing sync) pulses ERR, discards the beat, sets SLOT=0, moves to HUNT.
- Early sync (RUN, SLOT!=0, beat with FS=1):
  - ERR pulses.
  - Partial frame is abandoned; Y is not updated.
  - The beat is taken as slot 0: shadow[0] written, SLOT=1, state stays RUN.
- Y updates only on frame completion; between completions it holds the last complete frame.
- Y_VLD and ERR never assert in the same cycle, since each is produced by a distinct beat type.
- Back-to-back frames with a beat every cycle are supported: throughput is one slot per cycle, no bubbles.
- Reset asserted mid-frame drops the partial frame; the block restarts in HUNT.

Optional Feature:
TDM_DEMUX_CNT_EN
- Defined: adds two outputs.
  - FRM_CNT, 16 bits: increments on each Y_VLD.
  - ERR_CNT, 16 bits: increments on each ERR.
  - Both saturate at 16'hFFFF, reset to 0, and hold while E=0.
- Undefined: neither port nor counter exists.
- Core behaviour is identical in both builds.

Decomposition:
- Package tdm_demux_pkg holds:
  - state enum {HUNT, RUN}
  - default CH_NUM/W constants
  - counter width constant CNT_W=16
- One sub-module, tdm_slot_cnt, owns the SLOT register and its operations:
  - increment
  - wrap at CH_NUM-1
  - load to 1
  - clear to 0
  - a last-slot flag
- The top level holds the FSM, shadow/Y registers and the optional counters.

Test Plan:
- Reset: RST_N=0 asserted asynchronously mid-cycle -> Y=0, Y_VLD=0, ERR=0, SLOT=0 immediately; then RST_N=1 and beats 0x11 FS=0 -> discarded, SLOT stays 0.
- Nominal frame, CH_NUM=4: beats 0xA0(FS=1), 0xA1, 0xA2, 0xA3 on consecutive cycles -> one cycle after 0xA3, Y=0xA3A2A1A0 and Y_VLD=1 for exactly 1 cycle; SLOT sequence 1,2,3,0.
- Back-to-back: two frames 0x10..0x13 then 0x20..0x23, no gaps -> Y_VLD pulses 4 cycles apart; Y=0x13121110 then 0x23222120.
- Early sync: 0xB0(FS=1), 0xB1, 0xC0(FS=1), 0xC1, 0xC2, 0xC3 -> ERR pulse one cycle after the 0xC0 beat; single Y_VLD with Y=0xC3C2C1C0; Y never shows the 0xB* data.
- Missing sync and enable: after a complete frame, beat 0xD0 with FS=0 -> ERR pulse, state HUNT. Then E=0 during a frame -> beats ignored, SLOT held, completion delayed by the number of E=0 cycles.
- With TDM_DEMUX_CNT_EN: run 3 good frames plus 2 error events -> FRM_CNT=3, ERR_CNT=2. Preload via force to 16'hFFFF then one more frame -> FRM_CNT stays 16'hFFFF.
